ctr_buffer: RTL and testbench
=============================

// Module: ctr_buffer
// PURPOSE
//  Control transfer records storage, directly downstream of the CTR emitter.
//  - Accepts up to NrCommitPorts completed records (source/target/data) per cycle.
//  - Writes them in commit-port order into a circular buffer.
//  - Maintains the sctrstatus WRPTR/FROZEN state.
//  - Serves logical-index reads (0 = newest) for the ctrsource/ctrtarget/ctrdata CSR path.
// PARAMETERS
//  CVA6Cfg    cva6_cfg_empty  core configuration; NrCommitPorts sets the record ports
//  NrEntries  16              physical entries; power of two, 16..256
// PORTS
//  clk_i           in   1                     subsystem clock
//  rstn_i          in   1                     asynchronous reset, active low
//  source_i        in   NrCommitPorts x XLEN  record source (ctrsource_rv_t); .v marks the record valid
//  target_i        in   NrCommitPorts x XLEN  record target (ctrtarget_rv_t)
//  data_i          in   NrCommitPorts x XLEN  record data (ctrdata_rv_t)
//  enable_i        in   1                     recording allowed this cycle (mode/filter result)
//  freeze_i        in   1                     set FROZEN (LCOFI / breakpoint freeze event)
//  clr_i           in   1                     sctrclr: invalidate all entries, WRPTR := 0
//  depth_i         in   3                     sctrdepth.DEPTH encoding
//  status_we_i     in   1                     CSR write to sctrstatus
//  status_wdata_i  in   ctr_status_t          new WRPTR/FROZEN value
//  rd_idx_i        in   8                     logical read index, 0 = most recent
//  rd_source_o     out  XLEN                  entry source at rd_idx_i
//  rd_target_o     out  XLEN                  entry target at rd_idx_i
//  rd_data_o       out  XLEN                  entry data at rd_idx_i
//  status_o        out  ctr_status_t          current WRPTR and FROZEN
// BEHAVIOUR
//  - Reset: all entries zero (v=0), WRPTR=0, FROZEN=0; all outputs zero.
//  - Effective depth D = min(16 << depth_i, NrEntries). depth_i > 4 is treated as 4.
//  - Write condition: a record on port k is written iff source_i[k].v & enable_i & ~FROZEN.
//  - Placement: the k-th written record goes to (WRPTR + n_k) mod D.
//    - n_k = number of written records on ports < k.
//    - Next WRPTR = (WRPTR + total written) mod D.
//    - Write latency: 1 cycle; the record is readable in the cycle after commit.
//  - Wrap-around: the oldest entries are overwritten silently; there is no full stall and no overflow flag.
//  - Same-cycle writes to one slot: only possible when written records > D. Not possible with D >= 16.
//  - Read path, combinational from the flops:
//    - Physical index = (WRPTR - 1 - rd_idx_i) mod D.
//    - rd_idx_i >= D returns all-zero.
//    - Reads never alter state.
//  - freeze_i: FROZEN := 1 (sticky). Records on the same cycle as freeze_i are still written; freeze blocks from the next cycle.
//  - status_we_i: WRPTR := wdata.wrptr mod D; FROZEN := wdata.frozen. Records on that cycle are dropped.
//  - clr_i: all entries v := 0 and zeroed, WRPTR := 0, FROZEN unchanged. Records on that cycle are dropped.
//  - Priority when simultaneous: clr_i > status_we_i > freeze_i > record writes.
//  - Depth change (depth_i differs from the previous cycle):
//    - WRPTR := WRPTR mod new D.
//    - Entries >= new D keep their contents but are unreachable until depth grows again.
//  - Reset mid-operation: asynchronous clear to the reset state; no partial writes survive.
// STRUCTURE
//  - riscv package: ctr_status_t {wrptr[7:0], frozen}, CTR_DEPTH_MIN=16, CTR_DEPTH_MAX=256.
//    Reuse the existing ctrsource_rv_t / ctrtarget_rv_t / ctrdata_rv_t.
//  - Single module. Storage is three flop arrays of NrEntries.
//  - Per-port offsets come from a prefix-popcount loop over the written mask.
//  - No sub-module is needed.
// TESTING
//  1. Reset, then 3 single records (src 0x100/0x200/0x300) -> WRPTR=3; idx0 src=0x300, idx2 src=0x100, idx3 all-zero.
//  2. NrCommitPorts=2, both ports valid -> both land in one cycle; WRPTR += 2; port1 record is idx0.
//  3. D=16: write 18 records (src 0x10*i) -> WRPTR=2; idx0=0x110, idx15=0x20; no stall.
//  4. freeze_i with a record the same cycle -> that record is written; the next 4 records are dropped; WRPTR unchanged after.
//  5. clr_i with status_we_i and a valid record the same cycle -> all v=0, WRPTR=0, FROZEN unchanged, record dropped.
//  6. depth_i 1->0 with WRPTR=20 -> WRPTR=4; rd_idx_i=20 -> zero; rstn_i low mid-burst -> all zero next edge.

Source files
------------

// File: rtl/ctr_buffer_pkg.sv
// Shared types and constants for the control transfer record buffer.
// Record layouts mirror the ctrsource/ctrtarget/ctrdata CSR formats.
package ctr_buffer_pkg;

  localparam int unsigned XLEN          = 64;
  localparam int unsigned CTR_DEPTH_MIN = 16;
  localparam int unsigned CTR_DEPTH_MAX = 256;

  typedef struct packed {
    int unsigned NrCommitPorts;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{NrCommitPorts: 2};

  typedef struct packed {
    logic [XLEN-2:0] pc;
    logic            v;
  } ctrsource_rv_t;

  typedef struct packed {
    logic [XLEN-2:0] pc;
    logic            misp;
  } ctrtarget_rv_t;

  typedef struct packed {
    logic [XLEN-5:0] cc_info;
    logic [3:0]      typ;
  } ctrdata_rv_t;

  typedef struct packed {
    logic [7:0] wrptr;
    logic       frozen;
  } ctr_status_t;

  // DEPTH encodings above 4 saturate at 256 entries, then clip to what is built.
  function automatic logic [8:0] eff_depth(input logic [2:0] depth, input logic [8:0] nr_entries);
    logic [2:0] sel;
    logic [8:0] d;
    sel = (depth > 3'd4) ? 3'd4 : depth;
    d   = 9'(CTR_DEPTH_MIN) << sel;
    return (d > nr_entries) ? nr_entries : d;
  endfunction

endpackage

// File: rtl/ctr_buffer.sv
// Circular store of committed control transfer records with sctrstatus WRPTR/FROZEN
// tracking and newest-first logical reads for the CSR path.
module ctr_buffer
  import ctr_buffer_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg   = cva6_cfg_empty,
  parameter int unsigned NrEntries = 16
) (
  input  logic                                     clk_i,
  input  logic                                     rstn_i,
  input  ctrsource_rv_t [CVA6Cfg.NrCommitPorts-1:0] source_i,
  input  ctrtarget_rv_t [CVA6Cfg.NrCommitPorts-1:0] target_i,
  input  ctrdata_rv_t   [CVA6Cfg.NrCommitPorts-1:0] data_i,
  input  logic                                     enable_i,
  input  logic                                     freeze_i,
  input  logic                                     clr_i,
  input  logic [2:0]                               depth_i,
  input  logic                                     status_we_i,
  input  ctr_status_t                              status_wdata_i,
  input  logic [7:0]                               rd_idx_i,
  output ctrsource_rv_t                            rd_source_o,
  output ctrtarget_rv_t                            rd_target_o,
  output ctrdata_rv_t                              rd_data_o,
  output ctr_status_t                              status_o
);

  localparam int unsigned NrPorts = CVA6Cfg.NrCommitPorts;
  localparam int unsigned IdxW    = $clog2(NrEntries);

  ctrsource_rv_t r_source [NrEntries];
  ctrtarget_rv_t r_target [NrEntries];
  ctrdata_rv_t   r_data   [NrEntries];
  ctr_status_t   r_status;

  logic [8:0]         w_depth;
  logic [7:0]         w_mask;
  logic [NrPorts-1:0] w_wr_mask;
  logic [IdxW-1:0]    w_slot [NrPorts];
  logic [7:0]         w_total;
  logic [7:0]         w_cnt;
  logic               w_rd_hit;
  logic [IdxW-1:0]    w_rd_phys;

  assign w_depth = eff_depth(depth_i, 9'(NrEntries));
  assign w_mask  = 8'(w_depth - 9'd1);

  // clr/status writes outrank records, so they gate the write mask directly.
  generate
    for (genvar gi = 0; gi < NrPorts; gi++) begin : g_wr_mask
      assign w_wr_mask[gi] = source_i[gi].v & enable_i & ~r_status.frozen & ~clr_i & ~status_we_i;
    end
  endgenerate

  always_comb begin
    w_cnt = 8'd0;
    for (int k = 0; k < NrPorts; k++) begin
      w_slot[k] = IdxW'((r_status.wrptr + w_cnt) & w_mask);
      w_cnt     = w_cnt + 8'(w_wr_mask[k]);
    end
    w_total = w_cnt;
  end

  // Masking WRPTR every cycle also folds it into a shrunken depth window.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_status <= '0;
    end else if (clr_i) begin
      r_status.wrptr <= 8'd0;
    end else if (status_we_i) begin
      r_status.wrptr  <= status_wdata_i.wrptr & w_mask;
      r_status.frozen <= status_wdata_i.frozen;
    end else begin
      r_status.wrptr <= (r_status.wrptr + w_total) & w_mask;
      if (freeze_i) begin
        r_status.frozen <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NrEntries; i++) begin
        r_source[i] <= '0;
        r_target[i] <= '0;
        r_data[i]   <= '0;
      end
    end else if (clr_i) begin
      for (int i = 0; i < NrEntries; i++) begin
        r_source[i] <= '0;
        r_target[i] <= '0;
        r_data[i]   <= '0;
      end
    end else begin
      for (int k = 0; k < NrPorts; k++) begin
        if (w_wr_mask[k]) begin
          r_source[w_slot[k]] <= source_i[k];
          r_target[w_slot[k]] <= target_i[k];
          r_data[w_slot[k]]   <= data_i[k];
        end
      end
    end
  end

  assign w_rd_hit  = {1'b0, rd_idx_i} < w_depth;
  assign w_rd_phys = IdxW'((r_status.wrptr - 8'd1 - rd_idx_i) & w_mask);

  assign rd_source_o = w_rd_hit ? r_source[w_rd_phys] : '0;
  assign rd_target_o = w_rd_hit ? r_target[w_rd_phys] : '0;
  assign rd_data_o   = w_rd_hit ? r_data[w_rd_phys]   : '0;
  assign status_o    = r_status;

endmodule

// File: tb/tb_ctr_buffer.sv
// Directed bench for ctr_buffer: two commit ports, 32 physical entries.
module tb_ctr_buffer;
  import ctr_buffer_pkg::*;

  logic                 clk_i;
  logic                 rstn_i;
  ctrsource_rv_t [1:0]  source_i;
  ctrtarget_rv_t [1:0]  target_i;
  ctrdata_rv_t   [1:0]  data_i;
  logic                 enable_i;
  logic                 freeze_i;
  logic                 clr_i;
  logic [2:0]           depth_i;
  logic                 status_we_i;
  ctr_status_t          status_wdata_i;
  logic [7:0]           rd_idx_i;
  ctrsource_rv_t        rd_source_o;
  ctrtarget_rv_t        rd_target_o;
  ctrdata_rv_t          rd_data_o;
  ctr_status_t          status_o;

  int n_pass  = 0;
  int n_total = 0;

  ctr_buffer #(
    .CVA6Cfg  ('{NrCommitPorts: 2}),
    .NrEntries(32)
  ) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .source_i      (source_i),
    .target_i      (target_i),
    .data_i        (data_i),
    .enable_i      (enable_i),
    .freeze_i      (freeze_i),
    .clr_i         (clr_i),
    .depth_i       (depth_i),
    .status_we_i   (status_we_i),
    .status_wdata_i(status_wdata_i),
    .rd_idx_i      (rd_idx_i),
    .rd_source_o   (rd_source_o),
    .rd_target_o   (rd_target_o),
    .rd_data_o     (rd_data_o),
    .status_o      (status_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic ctrsource_rv_t mk_src(input logic [62:0] pc);
    mk_src = '{pc: pc, v: 1'b1};
  endfunction

  function automatic ctrtarget_rv_t mk_tgt(input logic [62:0] pc);
    mk_tgt = '{pc: pc + 63'd4, misp: 1'b0};
  endfunction

  function automatic ctrdata_rv_t mk_dat(input logic [62:0] pc);
    mk_dat = '{cc_info: 60'(pc), typ: 4'h1};
  endfunction

  function automatic ctr_status_t mk_st(input logic [7:0] wp, input logic fz);
    mk_st = '{wrptr: wp, frozen: fz};
  endfunction

  task automatic idle();
    source_i       = '0;
    target_i       = '0;
    data_i         = '0;
    enable_i       = 1'b1;
    freeze_i       = 1'b0;
    clr_i          = 1'b0;
    status_we_i    = 1'b0;
    status_wdata_i = '0;
  endtask

  task automatic put(input int k, input logic [62:0] pc);
    source_i[k] = mk_src(pc);
    target_i[k] = mk_tgt(pc);
    data_i[k]   = mk_dat(pc);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rd(input logic [7:0] idx);
    rd_idx_i = idx;
    #1;
  endtask

  task automatic test_reset();
    n_total++;
    if (status_o !== mk_st(8'd0, 1'b0)) $display("FAIL reset_status: got %h want %h", status_o, mk_st(8'd0, 1'b0));
    else n_pass++;
    rd(8'd0);
    n_total++;
    if ({rd_source_o, rd_target_o, rd_data_o} !== '0) $display("FAIL reset_read: got %h want 0", rd_source_o);
    else n_pass++;
    $display("reset: status=%h", status_o);
  endtask

  task automatic test_single();
    idle(); put(0, 63'h100); cyc();
    idle(); rd(8'd0);
    n_total++;
    if (rd_source_o !== mk_src(63'h100)) $display("FAIL single_latency: got %h want %h", rd_source_o, mk_src(63'h100));
    else n_pass++;
    put(0, 63'h200); cyc();
    idle(); put(0, 63'h300); cyc();
    idle(); rd(8'd0);
    n_total++;
    if (status_o !== mk_st(8'd3, 1'b0)) $display("FAIL single_wrptr: got %h want %h", status_o, mk_st(8'd3, 1'b0));
    else n_pass++;
    n_total++;
    if ({rd_source_o, rd_target_o, rd_data_o} !== {mk_src(63'h300), mk_tgt(63'h300), mk_dat(63'h300)})
      $display("FAIL single_idx0: got %h want %h", rd_source_o, mk_src(63'h300));
    else n_pass++;
    rd(8'd2);
    n_total++;
    if (rd_source_o !== mk_src(63'h100)) $display("FAIL single_idx2: got %h want %h", rd_source_o, mk_src(63'h100));
    else n_pass++;
    rd(8'd3);
    n_total++;
    if ({rd_source_o, rd_target_o, rd_data_o} !== '0) $display("FAIL single_idx3: got %h want 0", rd_source_o);
    else n_pass++;
    $display("single: wrptr=%0d", status_o.wrptr);
  endtask

  task automatic test_dual();
    idle(); put(0, 63'h400); put(1, 63'h500); cyc();
    idle(); rd(8'd0);
    n_total++;
    if (status_o !== mk_st(8'd5, 1'b0)) $display("FAIL dual_wrptr: got %h want %h", status_o, mk_st(8'd5, 1'b0));
    else n_pass++;
    n_total++;
    if (rd_source_o !== mk_src(63'h500)) $display("FAIL dual_idx0: got %h want %h", rd_source_o, mk_src(63'h500));
    else n_pass++;
    rd(8'd1);
    n_total++;
    if (rd_source_o !== mk_src(63'h400)) $display("FAIL dual_idx1: got %h want %h", rd_source_o, mk_src(63'h400));
    else n_pass++;
    put(1, 63'h600); cyc();
    idle(); rd(8'd0);
    n_total++;
    if (rd_source_o !== mk_src(63'h600) || status_o.wrptr !== 8'd6)
      $display("FAIL dual_port1_only: got src=%h wrptr=%0d want %h wrptr=6", rd_source_o, status_o.wrptr, mk_src(63'h600));
    else n_pass++;
    $display("dual: wrptr=%0d", status_o.wrptr);
  endtask

  task automatic test_wrap();
    idle(); clr_i = 1'b1; cyc();
    idle(); rd(8'd0);
    n_total++;
    if (status_o.wrptr !== 8'd0 || rd_source_o !== '0)
      $display("FAIL wrap_clear: got wrptr=%0d src=%h want 0/0", status_o.wrptr, rd_source_o);
    else n_pass++;
    for (int i = 0; i < 18; i++) begin
      idle(); put(0, 63'(16 * i)); cyc();
    end
    idle(); rd(8'd0);
    n_total++;
    if (status_o !== mk_st(8'd2, 1'b0)) $display("FAIL wrap_wrptr: got %h want %h", status_o, mk_st(8'd2, 1'b0));
    else n_pass++;
    n_total++;
    if (rd_source_o !== mk_src(63'h110)) $display("FAIL wrap_idx0: got %h want %h", rd_source_o, mk_src(63'h110));
    else n_pass++;
    rd(8'd1);
    n_total++;
    if (rd_source_o !== mk_src(63'h100)) $display("FAIL wrap_idx1: got %h want %h", rd_source_o, mk_src(63'h100));
    else n_pass++;
    rd(8'd15);
    n_total++;
    if (rd_source_o !== mk_src(63'h20)) $display("FAIL wrap_idx15: got %h want %h", rd_source_o, mk_src(63'h20));
    else n_pass++;
    rd(8'd16);
    n_total++;
    if (rd_source_o !== '0) $display("FAIL wrap_idx16: got %h want 0", rd_source_o);
    else n_pass++;
    $display("wrap: wrptr=%0d", status_o.wrptr);
  endtask

  task automatic test_freeze();
    idle(); freeze_i = 1'b1; put(0, 63'h700); cyc();
    for (int i = 0; i < 2; i++) begin
      idle(); put(0, 63'h800 + 63'(i)); put(1, 63'h900 + 63'(i)); cyc();
    end
    idle(); rd(8'd0);
    n_total++;
    if (status_o !== mk_st(8'd3, 1'b1)) $display("FAIL freeze_status: got %h want %h", status_o, mk_st(8'd3, 1'b1));
    else n_pass++;
    n_total++;
    if (rd_source_o !== mk_src(63'h700)) $display("FAIL freeze_idx0: got %h want %h", rd_source_o, mk_src(63'h700));
    else n_pass++;
    $display("freeze: status=%h", status_o);
  endtask

  task automatic test_clr();
    int nz;
    idle(); clr_i = 1'b1; status_we_i = 1'b1; status_wdata_i = mk_st(8'd7, 1'b0); put(0, 63'hA00); cyc();
    idle();
    n_total++;
    if (status_o !== mk_st(8'd0, 1'b1)) $display("FAIL clr_status: got %h want %h", status_o, mk_st(8'd0, 1'b1));
    else n_pass++;
    nz = 0;
    for (int i = 0; i < 16; i++) begin
      rd(8'(i));
      if ({rd_source_o, rd_target_o, rd_data_o} !== '0) nz++;
    end
    n_total++;
    if (nz !== 0) $display("FAIL clr_entries: got %0d nonzero want 0", nz);
    else n_pass++;
    idle(); status_we_i = 1'b1; status_wdata_i = mk_st(8'h25, 1'b0); freeze_i = 1'b1; put(0, 63'hB00); cyc();
    idle(); rd(8'd0);
    n_total++;
    if (status_o !== mk_st(8'd5, 1'b0)) $display("FAIL status_we: got %h want %h", status_o, mk_st(8'd5, 1'b0));
    else n_pass++;
    n_total++;
    if (rd_source_o !== '0) $display("FAIL status_we_drop: got %h want 0", rd_source_o);
    else n_pass++;
    $display("clr: status=%h", status_o);
  endtask

  task automatic test_depth();
    idle(); depth_i = 3'd1; status_we_i = 1'b1; status_wdata_i = mk_st(8'd18, 1'b0); cyc();
    idle(); put(0, 63'hA0); put(1, 63'hB0); cyc();
    idle(); rd(8'd0);
    n_total++;
    if (status_o.wrptr !== 8'd20 || rd_source_o !== mk_src(63'hB0))
      $display("FAIL depth32_write: got wrptr=%0d src=%h want 20 %h", status_o.wrptr, rd_source_o, mk_src(63'hB0));
    else n_pass++;
    depth_i = 3'd7; cyc();
    rd(8'd0);
    n_total++;
    if (status_o.wrptr !== 8'd20 || rd_source_o !== mk_src(63'hB0))
      $display("FAIL depth_sat: got wrptr=%0d src=%h want 20 %h", status_o.wrptr, rd_source_o, mk_src(63'hB0));
    else n_pass++;
    depth_i = 3'd0; cyc();
    n_total++;
    if (status_o.wrptr !== 8'd4) $display("FAIL depth_shrink: got wrptr=%0d want 4", status_o.wrptr);
    else n_pass++;
    rd(8'd20);
    n_total++;
    if (rd_source_o !== '0) $display("FAIL depth_idx20: got %h want 0", rd_source_o);
    else n_pass++;
    depth_i = 3'd1; status_we_i = 1'b1; status_wdata_i = mk_st(8'd20, 1'b0); cyc();
    idle(); rd(8'd1);
    n_total++;
    if (rd_source_o !== mk_src(63'hA0)) $display("FAIL depth_regrow: got %h want %h", rd_source_o, mk_src(63'hA0));
    else n_pass++;
    $display("depth: wrptr=%0d", status_o.wrptr);
  endtask

  task automatic test_reset_mid();
    idle(); put(0, 63'hC00); put(1, 63'hD00); cyc();
    put(0, 63'hE00); put(1, 63'hF00);
    #2 rstn_i = 1'b0;
    #1;
    n_total++;
    if (status_o !== mk_st(8'd0, 1'b0)) $display("FAIL rst_async: got %h want 0", status_o);
    else n_pass++;
    cyc();
    rd(8'd0);
    n_total++;
    if (status_o !== '0 || {rd_source_o, rd_target_o, rd_data_o} !== '0)
      $display("FAIL rst_mid: got status=%h src=%h want 0/0", status_o, rd_source_o);
    else n_pass++;
    idle(); rstn_i = 1'b1; cyc();
    rd(8'd21);
    n_total++;
    if (rd_source_o !== '0) $display("FAIL rst_entries: got %h want 0", rd_source_o);
    else n_pass++;
    $display("reset_mid: status=%h", status_o);
  endtask

  initial begin
    rstn_i   = 1'b0;
    depth_i  = 3'd0;
    rd_idx_i = 8'd0;
    idle();
    cyc(); cyc();
    test_reset();
    rstn_i = 1'b1;
    cyc();
    test_reset();
    test_single();
    test_dual();
    test_wrap();
    test_freeze();
    test_clr();
    test_depth();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
